// File: rtl/sram_synaptic_rmw.sv
// Synaptic weight memory: packed signed weights with an inference read port,
// a pipelined saturating read-modify-write learning port and a background clear.
//
// state | meaning
// IDLE  | reads and updates accepted; clear may be started
// CLEAR | one zero write per cycle sweeping address 0..SRAM_DEPTH-1
module sram_synaptic_rmw #(
    parameter int ADDR_WIDTH   = 8,
    parameter int SRAM_DEPTH   = 256,
    parameter int NUM_LANES    = 4,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DELTA_WIDTH  = 8,
    localparam int DATA_WIDTH  = NUM_LANES * WEIGHT_WIDTH
) (
    input  logic                               CK,
    input  logic                               RST,
    input  logic                               RD_EN,
    input  logic [ADDR_WIDTH-1:0]              RD_ADDR,
    output logic [DATA_WIDTH-1:0]              RD_DATA,
    output logic                               RD_VALID,
    input  logic                               UPD_VALID,
    output logic                               UPD_READY,
    input  logic [ADDR_WIDTH-1:0]              UPD_ADDR,
    input  logic [NUM_LANES*DELTA_WIDTH-1:0]   UPD_DELTA,
    input  logic [NUM_LANES-1:0]               UPD_MASK,
    input  logic                               CLR_START,
    output logic                               BUSY,
    output logic                               CLR_DONE
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SRAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

    state_t                     state;
    state_t                     state_nxt;
    logic [ADDR_WIDTH-1:0]      clr_cnt;
    logic [ADDR_WIDTH-1:0]      clr_cnt_nxt;
    logic                       clr_done_nxt;
    logic                       clr_wr;
    logic                       rd_accept;
    logic                       upd_accept;

    logic                            s1_valid;
    logic [ADDR_WIDTH-1:0]           s1_addr;
    logic [NUM_LANES*DELTA_WIDTH-1:0] s1_delta;
    logic [NUM_LANES-1:0]            s1_mask;
    logic [DATA_WIDTH-1:0]           s1_old;
    logic [DATA_WIDTH-1:0]           s1_new;
    logic [DATA_WIDTH-1:0]           upd_old;

    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0]      wr_data;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            CLR_DONE <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            CLR_DONE <= clr_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        clr_done_nxt = 1'b0;
        clr_wr       = 1'b0;
        rd_accept    = 1'b0;
        UPD_READY    = 1'b0;
        BUSY         = 1'b0;
        case (state)
            IDLE: begin
                UPD_READY = ~CLR_START;
                rd_accept = RD_EN;
                if (CLR_START) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                BUSY        = 1'b1;
                clr_wr      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt    = IDLE;
                    clr_cnt_nxt  = '0;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign upd_accept = UPD_VALID & UPD_READY;

    // Back-to-back updates to one address must see the result still in flight.
    assign upd_old = (s1_valid && (s1_addr == UPD_ADDR)) ? s1_new : mem[UPD_ADDR];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [WEIGHT_WIDTH-1:0] old_w;
        logic [DELTA_WIDTH-1:0]  dlt;
        logic [WEIGHT_WIDTH:0]   sum;
        logic [WEIGHT_WIDTH-1:0] sat;

        assign old_w = s1_old[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign dlt   = s1_delta[g*DELTA_WIDTH +: DELTA_WIDTH];
        assign sum   = {old_w[WEIGHT_WIDTH-1], old_w}
                     + {{(WEIGHT_WIDTH+1-DELTA_WIDTH){dlt[DELTA_WIDTH-1]}}, dlt};

        // Disagreeing top two bits of the widened sum mean overflow; the top bit gives direction.
        always_comb begin
            sat = sum[WEIGHT_WIDTH-1:0];
            if (sum[WEIGHT_WIDTH] != sum[WEIGHT_WIDTH-1]) begin
                sat = sum[WEIGHT_WIDTH] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
            end
        end

        assign s1_new[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = s1_mask[g] ? sat : old_w;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_delta <= '0;
            s1_mask  <= '0;
            s1_old   <= '0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            s1_valid <= upd_accept;
            if (upd_accept) begin
                s1_addr  <= UPD_ADDR;
                s1_delta <= UPD_DELTA;
                s1_mask  <= UPD_MASK;
                s1_old   <= upd_old;
            end
            RD_VALID <= rd_accept;
            if (rd_accept) begin
                RD_DATA <= mem[RD_ADDR];
            end
        end
    end

    // S1 is never valid while clearing, so the two write sources never overlap.
    assign wr_en   = s1_valid | clr_wr;
    assign wr_addr = clr_wr ? clr_cnt : s1_addr;
    assign wr_data = clr_wr ? '0 : s1_new;

    always_ff @(posedge CK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sram_synaptic_rmw.sv
// Directed bench for sram_synaptic_rmw: read port, saturating masked updates,
// forwarding, clear sweep and reset during clear.
module tb_sram_synaptic_rmw;

    logic        CK = 1'b0;
    logic        RST;
    logic        RD_EN;
    logic [7:0]  RD_ADDR;
    logic [31:0] RD_DATA;
    logic        RD_VALID;
    logic        UPD_VALID;
    logic        UPD_READY;
    logic [7:0]  UPD_ADDR;
    logic [31:0] UPD_DELTA;
    logic [3:0]  UPD_MASK;
    logic        CLR_START;
    logic        BUSY;
    logic        CLR_DONE;

    int errors = 0;
    int checks = 0;

    sram_synaptic_rmw dut (
        .CK        (CK),
        .RST       (RST),
        .RD_EN     (RD_EN),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .UPD_VALID (UPD_VALID),
        .UPD_READY (UPD_READY),
        .UPD_ADDR  (UPD_ADDR),
        .UPD_DELTA (UPD_DELTA),
        .UPD_MASK  (UPD_MASK),
        .CLR_START (CLR_START),
        .BUSY      (BUSY),
        .CLR_DONE  (CLR_DONE)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Accept one update, then idle one cycle so the write has landed on return.
    task automatic do_update(input logic [7:0] addr, input logic [31:0] delta, input logic [3:0] mask);
        UPD_VALID = 1'b1;
        UPD_ADDR  = addr;
        UPD_DELTA = delta;
        UPD_MASK  = mask;
        tick();
        UPD_VALID = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic valid);
        RD_EN   = 1'b1;
        RD_ADDR = addr;
        tick();
        RD_EN = 1'b0;
        data  = RD_DATA;
        valid = RD_VALID;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        do_read(addr, d, v);
        chk({tag, "_valid"}, 64'(v), 64'd1);
        chk(tag, 64'(d), 64'(exp));
    endtask

    // Starts a clear on the next edge and follows it to completion (bounded).
    task automatic run_clear(input string tag);
        int busy_n = 0;
        int done_n = 0;
        int rdv_n  = 0;
        CLR_START = 1'b1;
        tick();
        CLR_START = 1'b0;
        UPD_VALID = 1'b1;
        RD_EN     = 1'b1;
        RD_ADDR   = 8'd5;
        for (int i = 0; i < 300; i++) begin
            if (BUSY) busy_n++;
            if (CLR_DONE) done_n++;
            if (RD_VALID) rdv_n++;
            if (!BUSY) break;
            chk({tag, "_upd_ready_busy"}, 64'(UPD_READY), 64'd0);
            tick();
        end
        RD_EN     = 1'b0;
        UPD_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (CLR_DONE) done_n++;
        end
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd256);
        chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
        chk({tag, "_rd_ignored"}, 64'(rdv_n), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        int          done_n;

        RST = 1'b1; RD_EN = 1'b0; RD_ADDR = '0; UPD_VALID = 1'b0; UPD_ADDR = '0;
        UPD_DELTA = '0; UPD_MASK = '0; CLR_START = 1'b0;
        repeat (3) tick();
        chk("rst_rd_valid", 64'(RD_VALID), 64'd0);
        chk("rst_rd_data", 64'(RD_DATA), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_clr_done", 64'(CLR_DONE), 64'd0);
        chk("rst_upd_ready", 64'(UPD_READY), 64'd1);
        RST = 1'b0;
        tick();

        run_clear("init");

        // Preload and read-hold
        do_update(8'd5, 32'h10203040, 4'b1111);
        read_chk("rd5", 8'd5, 32'h10203040);
        tick();
        chk("hold_valid", 64'(RD_VALID), 64'd0);
        chk("hold_data", 64'(RD_DATA), 64'h10203040);

        // Saturation on all lanes
        do_update(8'd3, 32'h7F8001FF, 4'b1111);
        read_chk("pre3", 8'd3, 32'h7F8001FF);
        do_update(8'd3, 32'h01FF05FE, 4'b1111);
        read_chk("sat3", 8'd3, 32'h7F8006FD);

        // Masked lanes pass through
        do_update(8'd9, 32'h03030303, 4'b0101);
        read_chk("mask9", 8'd9, 32'h00030003);

        // Back-to-back same-address updates through forwarding
        UPD_VALID = 1'b1; UPD_ADDR = 8'd7; UPD_DELTA = 32'h0000000A; UPD_MASK = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_ready", 64'(UPD_READY), 64'd1);
            tick();
        end
        UPD_VALID = 1'b0;
        tick();
        read_chk("b2b7", 8'd7, 32'h0000001E);

        // Read in the cycle after acceptance sees the pre-write word
        UPD_VALID = 1'b1; UPD_ADDR = 8'd9; UPD_DELTA = 32'h01010101; UPD_MASK = 4'b1111;
        tick();
        UPD_VALID = 1'b0;
        read_chk("rbw_old9", 8'd9, 32'h00030003);
        read_chk("rbw_new9", 8'd9, 32'h01040104);

        // Update accepted right before clear; clear-edge update blocked
        UPD_VALID = 1'b1; UPD_ADDR = 8'd7; UPD_DELTA = 32'h00000001; UPD_MASK = 4'b0001;
        tick();
        CLR_START = 1'b1;
        #1;
        chk("clr_start_ready", 64'(UPD_READY), 64'd0);
        run_clear("clr");
        read_chk("clr_rd0", 8'd0, 32'h0);
        read_chk("clr_rd7", 8'd7, 32'h0);
        read_chk("clr_rd255", 8'd255, 32'h0);

        // Reset aborts a clear after 100 writes
        do_update(8'd0,   32'h11223344, 4'b1111);
        do_update(8'd99,  32'h11223344, 4'b1111);
        do_update(8'd100, 32'h11223344, 4'b1111);
        do_update(8'd200, 32'h11223344, 4'b1111);
        CLR_START = 1'b1;
        tick();
        CLR_START = 1'b0;
        done_n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (CLR_DONE) done_n++;
        end
        chk("abort_busy_before", 64'(BUSY), 64'd1);
        RST = 1'b1;
        #1;
        chk("abort_busy", 64'(BUSY), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (CLR_DONE) done_n++;
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (CLR_DONE) done_n++;
        end
        chk("abort_no_done", 64'(done_n), 64'd0);
        read_chk("abort_rd0", 8'd0, 32'h0);
        read_chk("abort_rd99", 8'd99, 32'h0);
        read_chk("abort_rd100", 8'd100, 32'h11223344);
        read_chk("abort_rd200", 8'd200, 32'h11223344);
        do_read(8'd5, d, v);
        chk("abort_rd5", 64'(d), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_synaptic_rmw.md
Name: sram_synaptic_rmw

Overview:
Parametrised synaptic weight memory for the FF-STDP core. It packs NUM_LANES signed weights per word and provides:
- an inference read port (1-cycle latency);
- a pipelined read-modify-write learning port that applies a saturating signed delta to masked lanes;
- a background clear engine.

It replaces the plain single-port synaptic SRAM wherever on-chip weight updates are required. Array storage is behavioural: 1 write and 2 reads per cycle, mappable to a BRAM or SRAM macro.

Parameters:
ADDR_WIDTH, 8, word address width
SRAM_DEPTH, 256, number of words (must be ≤ 2^ADDR_WIDTH)
NUM_LANES, 4, weights per word
WEIGHT_WIDTH, 8, signed two's-complement weight width
DELTA_WIDTH, 8, signed delta width (must be ≤ WEIGHT_WIDTH)
DATA_WIDTH is derived as NUM_LANES*WEIGHT_WIDTH (localparam, not overridable). Lane i occupies bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].

Ports:
CK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous active-high reset
RD_EN  in  1  inference read request
RD_ADDR  in  ADDR_WIDTH  inference read address
RD_DATA  out  DATA_WIDTH  read data; holds its last value when no read completes
RD_VALID  out  1  high for the cycle after an accepted read
UPD_VALID  in  1  update request
UPD_READY  out  1  update port can accept
UPD_ADDR  in  ADDR_WIDTH  update address
UPD_DELTA  in  NUM_LANES*DELTA_WIDTH  per-lane signed deltas, packed like the data word
UPD_MASK  in  NUM_LANES  lane enable; a 0 lane is written back unchanged
CLR_START  in  1  request to zero the whole array
BUSY  out  1  clear in progress
CLR_DONE  out  1  one-cycle pulse after the last clear write

Behaviour:
- Reset: RD_DATA=0, RD_VALID=0, BUSY=0, CLR_DONE=0, FSM=IDLE, update pipeline invalid, clear counter=0. Array contents are not reset.
- FSM states are IDLE and CLEAR.
- UPD_READY = (state==IDLE) & ~CLR_START. It is combinational and does not depend on UPD_VALID.
- Read port (IDLE only):
  - An edge with RD_EN=1 registers RD_DATA from the array at RD_ADDR and sets RD_VALID=1 for the next cycle.
  - An edge with RD_EN=0 clears RD_VALID; RD_DATA holds.
  - Read and write to the same address on the same edge: RD_DATA gets the pre-write contents (read-before-write).
- Update pipeline:
  - Accept on an edge where UPD_VALID & UPD_READY. Stage S1 captures addr, delta, mask, and the old word.
  - If S1 is valid with the same address, the old word is the S1 computed result (forwarding), not the array contents.
  - During the S1 cycle, each lane i with mask[i]=1 computes sat(old_i + sext(delta_i)). Sum is computed in WEIGHT_WIDTH+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. Unmasked lanes pass through unchanged.
  - The new word is written to the array on the next edge.
  - Throughput is 1 update per cycle with no bubbles, including back-to-back updates to the same address.
  - Write lands 2 edges after acceptance relative to the accept cycle; a read issued in the cycle after acceptance sees the old value.
- Clear:
  - CLR_START=1 in IDLE moves to CLEAR at that edge and resets the counter to 0.
  - No update is accepted on that edge. An update already in S1 still writes on that same edge, so it never collides with clear writes.
  - In CLEAR: each edge writes 0 to address cnt and increments cnt. BUSY=1.
  - After writing address SRAM_DEPTH-1: return to IDLE, pulse CLR_DONE for one cycle, BUSY=0.
  - RD_EN and UPD_VALID are ignored in CLEAR (RD_VALID=0, UPD_READY=0).
  - CLR_START while in CLEAR is ignored.
- Reset mid-operation: an update in S1 is discarded (no write). A clear is aborted with a partially cleared array; no CLR_DONE is issued.
- Addresses ≥ SRAM_DEPTH are out of contract and need not be checked.

Test Plan:
- Preload word 5=0x10_20_30_40. Read 5 -> RD_VALID=1 and RD_DATA=0x10203040 on the next cycle. Hold RD_EN=0 -> RD_DATA stays, RD_VALID=0.
- Word 3=0x7F_80_01_FF, UPD deltas {+1,-1,+5,-2}, mask 1111 -> lanes saturate: word 3 becomes 0x7F_80_06_FD.
- Word 9=0x00000000, mask 0101, all deltas +3 -> word 9 = 0x00030003; lanes 1 and 3 unchanged.
- Three back-to-back updates to address 7, delta +10 on lane 0, initial 0 -> lane 0 = 30 (0x1E). UPD_READY stays 1 and no update is lost through forwarding.
- Update accepted in the cycle before CLR_START, SRAM_DEPTH=256 -> update writes first, then BUSY is high for 256 cycles. CLR_DONE pulses once, and reads of 0, 7 and 255 afterwards all return 0.
- Assert RST at clear count 100 -> BUSY=0 immediately, no CLR_DONE. Addresses 0..99 (clear writes that landed) read 0; address 200 retains its old value.
